// File: rtl/jtag_1149_d10_pkg.sv
// Shared types and constants for the JTAG 1149 D10 master transmit scheduler.
// Holds the FSM state encoding, field widths and default timing limits.
package jtag_1149_d10_pkg;

   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned WORD_W        = 16;
   localparam int unsigned TIMEOUT_DEF   = 1024;
   localparam int unsigned MAX_RETRY_DEF = 3;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StIssue    = 2'd1,
      StWaitDone = 2'd2
   } state_e;

   // Width helper that never returns zero, so single-entry counters stay legal.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/jtag_1149_d10_rr_arb.sv
// Round-robin arbiter: one-hot grant starting after the last granted requester.
// The pointer advances only when en is high and some request is present.
module jtag_1149_d10_rr_arb
   import jtag_1149_d10_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt
);

   localparam int unsigned PtrW = clog2_min1(NUM_REQ);

   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] req_hi;
   logic [NUM_REQ-1:0] req_src;
   int                 win_idx;

   // Requests at or above the pointer win first; otherwise wrap to the lowest.
   always_comb begin
      req_hi = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         req_hi[i] = req[i] && (i >= int'(ptr_q));
      end
      req_src = (|req_hi) ? req_hi : req;
   end

   always_comb begin
      gnt     = '0;
      win_idx = 0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_src[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            win_idx = i;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (en && (|req)) begin
         ptr_d = (win_idx == int'(NUM_REQ) - 1) ? '0 : PtrW'(win_idx + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/jtag_1149_d10_mstr_tx_sched.sv
// Master transmit scheduler: grants compliance or packet requests, launches them
// to the Tx controller, and tracks completion, retries and timeout.
module jtag_1149_d10_mstr_tx_sched
   import jtag_1149_d10_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
   parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cc_req,
   output logic                      cc_ack,
   input  logic [NUM_REQ-1:0]        pkt_req,
   input  logic [NUM_REQ*BYTE_W-1:0] pkt_type,
   input  logic [NUM_REQ*WORD_W-1:0] pkt_tid,
   input  logic [NUM_REQ*WORD_W-1:0] pkt_val,
   output logic [NUM_REQ-1:0]        pkt_ack,
   input  logic                      suspend_xmission,
   input  logic                      instr_retry,
   input  logic                      pkt_txm_done,
   input  logic                      comp_char_done,
   output logic                      send_pkt_vld,
   output logic                      send_comp_char,
   output logic [BYTE_W-1:0]         send_pkt_type,
   output logic [WORD_W-1:0]         send_target_id,
   output logic [WORD_W-1:0]         send_reset_value,
   output logic                      busy,
   output logic                      timeout_err,
   output logic                      retry_exhausted
);

   localparam int unsigned CntW = clog2_min1(TIMEOUT);
   localparam int unsigned RetW = clog2_min1(MAX_RETRY + 1);

   state_e              state_q, state_d;
   logic                cc_q, cc_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
   logic [RetW-1:0]     retry_cnt_q, retry_cnt_d;
   logic [BYTE_W-1:0]   type_q, type_d;
   logic [WORD_W-1:0]   tid_q, tid_d;
   logic [WORD_W-1:0]   val_q, val_d;

   logic                idle, in_wait, grant_en;
   logic                grant_cc, grant_pkt;
   logic [NUM_REQ-1:0]  arb_gnt;
   logic [BYTE_W-1:0]   sel_type;
   logic [WORD_W-1:0]   sel_tid, sel_val;
   logic                done_hit, retry_hit, retry_ok, tmo_hit, finish;

   assign idle      = (state_q == StIdle);
   assign in_wait   = (state_q == StWaitDone);
   assign grant_en  = idle && !suspend_xmission && !cc_req;
   assign grant_cc  = idle && !suspend_xmission && cc_req;
   assign grant_pkt = grant_en && (|pkt_req);

   jtag_1149_d10_rr_arb #(
      .NUM_REQ(NUM_REQ)
   ) u_rr_arb (
      .clk(clk),
      .rst(rst),
      .req(pkt_req),
      .en (grant_en),
      .gnt(arb_gnt)
   );

   always_comb begin
      sel_type = '0;
      sel_tid  = '0;
      sel_val  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (arb_gnt[i]) begin
            sel_type = pkt_type[i*BYTE_W +: BYTE_W];
            sel_tid  = pkt_tid[i*WORD_W +: WORD_W];
            sel_val  = pkt_val[i*WORD_W +: WORD_W];
         end
      end
   end

   // Completion events; only the done matching the grant type counts, retry beats done.
   assign done_hit  = in_wait && (cc_q ? comp_char_done : pkt_txm_done);
   assign retry_hit = in_wait && !cc_q && instr_retry;
   assign retry_ok  = (retry_cnt_q < RetW'(MAX_RETRY));
   assign tmo_hit   = in_wait && (wait_cnt_q == CntW'(TIMEOUT - 1));
   assign finish    = retry_hit ? !retry_ok : (done_hit || tmo_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cc_q        <= 1'b0;
         gnt_q       <= '0;
         wait_cnt_q  <= '0;
         retry_cnt_q <= '0;
         type_q      <= '0;
         tid_q       <= '0;
         val_q       <= '0;
      end else begin
         state_q     <= state_d;
         cc_q        <= cc_d;
         gnt_q       <= gnt_d;
         wait_cnt_q  <= wait_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         type_q      <= type_d;
         tid_q       <= tid_d;
         val_q       <= val_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (grant_cc || grant_pkt) state_d = StIssue;
         StIssue:    state_d = StWaitDone;
         StWaitDone: begin
            if (retry_hit && retry_ok) begin
               state_d = StIssue;
            end else if (finish) begin
               state_d = StIdle;
            end
         end
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      cc_d        = cc_q;
      gnt_d       = gnt_q;
      wait_cnt_d  = wait_cnt_q;
      retry_cnt_d = retry_cnt_q;
      type_d      = type_q;
      tid_d       = tid_q;
      val_d       = val_q;
      if (grant_cc) begin
         cc_d        = 1'b1;
         gnt_d       = '0;
         retry_cnt_d = '0;
      end else if (grant_pkt) begin
         cc_d        = 1'b0;
         gnt_d       = arb_gnt;
         retry_cnt_d = '0;
         type_d      = sel_type;
         tid_d       = sel_tid;
         val_d       = sel_val;
      end
      if (state_q == StIssue) begin
         wait_cnt_d = '0;
      end else if (in_wait) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
         if (retry_hit && retry_ok) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      send_pkt_vld     = (state_q == StIssue) && !cc_q;
      send_comp_char   = (state_q == StIssue) && cc_q;
      busy             = !idle;
      cc_ack           = finish && cc_q;
      pkt_ack          = (finish && !cc_q) ? gnt_q : '0;
      timeout_err      = tmo_hit && !done_hit && !retry_hit;
      retry_exhausted  = retry_hit && !retry_ok;
      send_pkt_type    = type_q;
      send_target_id   = tid_q;
      send_reset_value = val_q;
   end

endmodule

// File: doc/jtag_1149_d10_mstr_tx_sched.md
JTAG_1149_D10_MSTR_TX_SCHED -- requirements
Module: jtag_1149_d10_mstr_tx_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of packet requesters.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for a done.
REQ-003 SHALL have parameter MAX_RETRY, default 3: maximum re-issues per transaction.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-005 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cc_req  in  1  compliance-character request (level)
- cc_ack  out  1  one-cycle pulse, compliance transaction finished
- pkt_req  in  NUM_REQ  per-requester packet request (level)
- pkt_type  in  NUM_REQ*8  packed packet types; requester i uses bits [8i+7:8i]
- pkt_tid  in  NUM_REQ*16  packed target IDs
- pkt_val  in  NUM_REQ*16  packed reset/raw values
- pkt_ack  out  NUM_REQ  one-hot pulse, transaction finished
- suspend_xmission  in  1  blocks new grants
- instr_retry  in  1  re-issue request for the current packet
- pkt_txm_done  in  1  packet completion from the Tx controller
- comp_char_done  in  1  compliance completion from the Tx controller
- send_pkt_vld  out  1  one-cycle packet launch
- send_comp_char  out  1  one-cycle compliance launch
- send_pkt_type  out  8  latched packet type
- send_target_id  out  16  latched target ID
- send_reset_value  out  16  latched value
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  one-cycle pulse on timeout
- retry_exhausted  out  1  one-cycle pulse on retry limit

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE.
REQ-007 In IDLE with suspend_xmission=0, a pending request SHALL cause a grant and a move to ISSUE on the next cycle; cc_req has strict priority over pkt_req.
REQ-008 Packet grants SHALL be round-robin:
- search starts at the index after the last-granted requester;
- after reset the pointer favours requester 0;
- the pointer updates only on a packet grant.
REQ-009 At grant, the requester's type, tid and val SHALL be latched into the send_* outputs and held constant until the next grant.
REQ-010 ISSUE SHALL last exactly one cycle:
- send_pkt_vld=1 for a packet grant, or send_comp_char=1 for a compliance grant;
- then move to WAIT_DONE with the wait counter and, on a first issue, retry_cnt cleared.
REQ-011 In WAIT_DONE the wait counter SHALL increment every cycle; only the done matching the grant type is honoured (pkt_txm_done for packets, comp_char_done for compliance).
REQ-012 When the matching done arrives, the FSM SHALL pulse the granted requester's ack in the same cycle and return to IDLE.
REQ-013 instr_retry in WAIT_DONE (packet grants only) SHALL behave as follows:
- if retry_cnt<MAX_RETRY: increment retry_cnt and return to ISSUE, keeping the latched fields;
- otherwise: pulse retry_exhausted and ack together, and go to IDLE.
REQ-014 When instr_retry and pkt_txm_done occur in the same cycle, the retry SHALL take priority.
REQ-015 When the wait counter reaches TIMEOUT-1 without a done, the block SHALL pulse timeout_err and ack together and go to IDLE; a done in that same cycle takes priority and suppresses timeout_err.
REQ-016 suspend_xmission SHALL only block grants in IDLE; it SHALL NOT affect ISSUE or WAIT_DONE.
REQ-017 pkt_req deasserting after grant SHALL be ignored; the transaction completes and the ack still pulses.
REQ-018 instr_retry during a compliance transaction, and stray done pulses in IDLE or ISSUE, SHALL be ignored.
REQ-019 At most one ack bit (pkt_ack or cc_ack) SHALL be high in any cycle.
REQ-020 The earliest back-to-back grant SHALL occur in the cycle after ack, from IDLE; minimum transaction length is 3 cycles.

Reset
REQ-021 rst SHALL take effect at the clk edge:
- FSM goes to IDLE;
- RR pointer, counters and retry_cnt go to 0;
- all outputs go to 0, including the latched send_* fields.
REQ-022 A reset during ISSUE or WAIT_DONE SHALL abandon the transaction with no ack pulse.

Structure
REQ-023 The shared package jtag_1149_d10_pkg SHALL hold the FSM state typedef, the BYTE/WORD width constants and the TIMEOUT/MAX_RETRY defaults.
REQ-024 Round-robin selection SHALL be a sub-module jtag_1149_d10_rr_arb (inputs: request vector, enable; outputs: one-hot grant; internal pointer).

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- pkt_req=3'b111 held, each done returned 5 cycles after issue -> grant order 0,1,2,0; each pkt_ack one cycle.
- cc_req and pkt_req[1] asserted together -> send_comp_char first, cc_ack, then send_pkt_vld with requester 1's fields.
- instr_retry on 4 consecutive issues (MAX_RETRY=3) -> 4 send_pkt_vld pulses, then retry_exhausted and pkt_ack[i] in the same cycle.
- no done returned (TIMEOUT=16) -> timeout_err and ack 16 cycles after ISSUE; done arriving in cycle 15 -> ack with no timeout_err.
- suspend_xmission high while pkt_req[2]=1 -> no grant; grant 1 cycle after suspend falls.
- rst asserted in WAIT_DONE -> outputs 0 next cycle, no ack, next grant goes to requester 0.
